// File: rtl/event_unit_mc_pkg.sv
// event_unit_mc_pkg: register map, address field bounds and sleep FSM states for the event unit
package event_unit_mc_pkg;
    localparam logic [3:0] REG_IRQ_MASK = 4'h0;
    localparam logic [3:0] REG_EVT_MASK = 4'h1;
    localparam logic [3:0] REG_IRQ_PEND = 4'h2;
    localparam logic [3:0] REG_EVT_PEND = 4'h3;
    localparam logic [3:0] REG_EVT_SET  = 4'h4;
    localparam logic [3:0] REG_SLEEP    = 4'h5;
    localparam logic [3:0] REG_STATUS   = 4'h6;
    localparam int CORE_IDX_MSB = 11;
    localparam int CORE_IDX_LSB = 6;
    localparam int REG_IDX_MSB  = 5;
    localparam int REG_IDX_LSB  = 2;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_IDLE = 2'd1,
        SLEEP     = 2'd2,
        WAKE      = 2'd3
    } sleep_state_e;
endpackage

// File: rtl/event_unit_core_ctrl.sv
// event_unit_core_ctrl: one core's masks, pending registers and sleep/wake FSM
module event_unit_core_ctrl
    import event_unit_mc_pkg::*;
#(
    parameter int NB_LINES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NB_LINES-1:0] irq_rise,
    input  logic [NB_LINES-1:0] evt_rise,
    input  logic                wr_en,
    input  logic [3:0]          wr_reg,
    input  logic [NB_LINES-1:0] wdata,
    input  logic                core_busy,
    output logic [NB_LINES-1:0] irq_mask,
    output logic [NB_LINES-1:0] evt_mask,
    output logic [NB_LINES-1:0] irq_pend,
    output logic [NB_LINES-1:0] evt_pend,
    output logic [NB_LINES-1:0] irq_out,
    output sleep_state_e        state,
    output logic                fetch_en,
    output logic                clk_en
);
    sleep_state_e        state_nxt;
    logic [NB_LINES-1:0] irq_clr, evt_clr, evt_set;
    logic                sleep_req, wake;

    assign irq_clr   = (wr_en && wr_reg == REG_IRQ_PEND) ? wdata : '0;
    assign evt_clr   = (wr_en && wr_reg == REG_EVT_PEND) ? wdata : '0;
    assign evt_set   = (wr_en && wr_reg == REG_EVT_SET) ? wdata : '0;
    assign sleep_req = wr_en && wr_reg == REG_SLEEP && wdata[0];
    assign irq_out   = irq_pend & irq_mask;
    assign wake      = |irq_out || |(evt_pend & evt_mask);

    // sets are OR-ed in after the clear so an edge wins over a same-cycle W1C
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_mask <= '0;
            evt_mask <= '0;
            irq_pend <= '0;
            evt_pend <= '0;
        end else begin
            if (wr_en && wr_reg == REG_IRQ_MASK) irq_mask <= wdata;
            if (wr_en && wr_reg == REG_EVT_MASK) evt_mask <= wdata;
            irq_pend <= irq_rise | (irq_pend & ~irq_clr);
            evt_pend <= evt_rise | evt_set | (evt_pend & ~evt_clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:       state_nxt = sleep_req ? WAIT_IDLE : RUN;
            WAIT_IDLE: state_nxt = wake ? RUN : (core_busy ? WAIT_IDLE : SLEEP);
            SLEEP:     state_nxt = wake ? WAKE : SLEEP;
            WAKE:      state_nxt = RUN;
            default:   state_nxt = RUN;
        endcase
        fetch_en = state == RUN;
        clk_en   = state != SLEEP;
    end
endmodule

// File: rtl/apb_event_unit_mc.sv
// apb_event_unit_mc: APB decode, read mux and shared edge detectors for the per-core event units
module apb_event_unit_mc
    import event_unit_mc_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NB_CORES       = 4,
    parameter int NB_LINES       = 32
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [APB_ADDR_WIDTH-1:0]    PADDR,
    input  logic [31:0]                  PWDATA,
    input  logic                         PWRITE,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    output logic [31:0]                  PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic [NB_LINES-1:0]          irq_i,
    input  logic [NB_LINES-1:0]          event_i,
    output logic [NB_CORES*NB_LINES-1:0] irq_o,
    input  logic [NB_CORES-1:0]          core_busy_i,
    output logic [NB_CORES-1:0]          fetch_enable_o,
    output logic [NB_CORES-1:0]          clk_gate_core_o
);
    localparam int CW = NB_CORES > 1 ? $clog2(NB_CORES) : 1;
    localparam logic [5:0] NC = 6'(NB_CORES);

    logic [NB_LINES-1:0] irq_s, irq_d, evt_s, evt_d, irq_rise, evt_rise;
    logic [NB_LINES-1:0] irq_mask [NB_CORES];
    logic [NB_LINES-1:0] evt_mask [NB_CORES];
    logic [NB_LINES-1:0] irq_pend [NB_CORES];
    logic [NB_LINES-1:0] evt_pend [NB_CORES];
    sleep_state_e        state    [NB_CORES];
    logic [5:0]          core_idx;
    logic [3:0]          reg_idx;
    logic [CW-1:0]       ci;
    logic                core_ok, reg_ok, access, wr;
    logic [31:0]         rdata;
    logic                unused_apb;

    assign core_idx   = PADDR[CORE_IDX_MSB:CORE_IDX_LSB];
    assign reg_idx    = PADDR[REG_IDX_MSB:REG_IDX_LSB];
    assign ci         = core_idx[CW-1:0];
    assign core_ok    = core_idx < NC;
    assign reg_ok     = reg_idx <= REG_STATUS;
    assign access     = PSEL && PENABLE;
    assign wr         = access && PWRITE && core_ok && reg_ok;
    assign PREADY     = 1'b1;
    assign PSLVERR    = access && !(core_ok && reg_ok);
    assign PRDATA     = (PSEL && core_ok && reg_ok) ? rdata : '0;
    assign irq_rise   = irq_s & ~irq_d;
    assign evt_rise   = evt_s & ~evt_d;
    assign unused_apb = ^{PADDR, PWDATA};

    // inputs are sampled first, the rise is taken between the sample and its delayed copy
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            irq_s <= '0;
            irq_d <= '0;
            evt_s <= '0;
            evt_d <= '0;
        end else begin
            irq_s <= irq_i;
            irq_d <= irq_s;
            evt_s <= event_i;
            evt_d <= evt_s;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_IRQ_MASK: rdata = 32'(irq_mask[ci]);
            REG_EVT_MASK: rdata = 32'(evt_mask[ci]);
            REG_IRQ_PEND: rdata = 32'(irq_pend[ci]);
            REG_EVT_PEND: rdata = 32'(evt_pend[ci]);
            REG_STATUS:   rdata = {29'b0, core_busy_i[ci], state[ci]};
            default:      rdata = '0;
        endcase
    end

    for (genvar c = 0; c < NB_CORES; c++) begin : g_core
        event_unit_core_ctrl #(.NB_LINES(NB_LINES)) u_ctrl (
            .clk       (HCLK),
            .rst       (HRESET),
            .irq_rise  (irq_rise),
            .evt_rise  (evt_rise),
            .wr_en     (wr && core_idx == 6'(c)),
            .wr_reg    (reg_idx),
            .wdata     (PWDATA[NB_LINES-1:0]),
            .core_busy (core_busy_i[c]),
            .irq_mask  (irq_mask[c]),
            .evt_mask  (evt_mask[c]),
            .irq_pend  (irq_pend[c]),
            .evt_pend  (evt_pend[c]),
            .irq_out   (irq_o[c*NB_LINES +: NB_LINES]),
            .state     (state[c]),
            .fetch_en  (fetch_enable_o[c]),
            .clk_en    (clk_gate_core_o[c])
        );
    end
endmodule

// File: tb/tb_apb_event_unit_mc.sv
// tb_apb_event_unit_mc: directed self-checking bench for apb_event_unit_mc
module tb_apb_event_unit_mc;
    localparam int NC = 4;
    localparam int NL = 32;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic [11:0]      PADDR;
    logic [31:0]      PWDATA;
    logic             PWRITE, PSEL, PENABLE;
    logic [31:0]      PRDATA;
    logic             PREADY, PSLVERR;
    logic [NL-1:0]    irq_i, event_i;
    logic [NC*NL-1:0] irq_o;
    logic [NC-1:0]    core_busy_i, fetch_enable_o, clk_gate_core_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] d;
    logic        e;

    apb_event_unit_mc #(.APB_ADDR_WIDTH(12), .NB_CORES(NC), .NB_LINES(NL)) dut (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .PADDR           (PADDR),
        .PWDATA          (PWDATA),
        .PWRITE          (PWRITE),
        .PSEL            (PSEL),
        .PENABLE         (PENABLE),
        .PRDATA          (PRDATA),
        .PREADY          (PREADY),
        .PSLVERR         (PSLVERR),
        .irq_i           (irq_i),
        .event_i         (event_i),
        .irq_o           (irq_o),
        .core_busy_i     (core_busy_i),
        .fetch_enable_o  (fetch_enable_o),
        .clk_gate_core_o (clk_gate_core_o)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] wd, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = wd;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] rd, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        #1 rd = PRDATA; err = PSLVERR;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        irq_i = '0; event_i = '0; core_busy_i = '0;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_fetch", 32'(fetch_enable_o), 32'hF);
        chk("rst_clk", 32'(clk_gate_core_o), 32'hF);
        chk("rst_irq_o", 32'(|irq_o), 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pslverr", 32'(PSLVERR), 32'h0);
        chk("rst_pready", 32'(PREADY), 32'h1);
        HRESET = 1'b0;
        for (int r = 0; r < 7; r++) begin
            apb_read(12'(r * 4), d, e);
            chk($sformatf("rst_reg%0d", r), d, 32'h0);
            chk($sformatf("rst_reg%0d_err", r), 32'(e), 32'h0);
        end

        // interrupt edge, masking and W1C
        apb_write(12'h040, 32'h4, e);
        irq_i = 32'h4;
        @(posedge HCLK); #1;
        irq_i = '0;
        chk("irq_latency1", irq_o[NL +: NL], 32'h0);
        @(posedge HCLK); #1;
        chk("irq_core1", irq_o[NL +: NL], 32'h4);
        chk("irq_core0", irq_o[0 +: NL], 32'h0);
        for (int c = 0; c < NC; c++) begin
            apb_read(12'(c * 64 + 8), d, e);
            chk($sformatf("irq_pend_c%0d", c), d, 32'h4);
        end
        apb_write(12'h048, 32'h4, e);
        chk("irq_w1c_out", irq_o[NL +: NL], 32'h0);
        apb_read(12'h048, d, e);
        chk("irq_w1c_c1", d, 32'h0);
        apb_read(12'h008, d, e);
        chk("irq_w1c_c0_kept", d, 32'h4);

        // core 2 sleep / wake on event
        apb_write(12'h084, 32'h1, e);
        core_busy_i = 4'b0100;
        apb_write(12'h094, 32'h1, e);
        chk("sleep_fetch_low", 32'(fetch_enable_o[2]), 32'h0);
        chk("sleep_clk_wait", 32'(clk_gate_core_o[2]), 32'h1);
        apb_read(12'h098, d, e);
        chk("status_wait_busy", d, 32'h5);
        repeat (2) @(posedge HCLK);
        #1;
        core_busy_i = 4'b0000;
        chk("clk_before_idle", 32'(clk_gate_core_o[2]), 32'h1);
        @(posedge HCLK); #1;
        chk("clk_gated", 32'(clk_gate_core_o[2]), 32'h0);
        apb_read(12'h098, d, e);
        chk("status_sleep", d, 32'h2);
        event_i = 32'h1;
        @(posedge HCLK); #1;
        event_i = '0;
        @(posedge HCLK); #1;
        chk("wake_pend_clk", 32'(clk_gate_core_o[2]), 32'h0);
        @(posedge HCLK); #1;
        chk("wake_clk", 32'(clk_gate_core_o[2]), 32'h1);
        chk("wake_fetch", 32'(fetch_enable_o[2]), 32'h0);
        @(posedge HCLK); #1;
        chk("run_fetch", 32'(fetch_enable_o[2]), 32'h1);
        apb_read(12'h098, d, e);
        chk("status_run", d, 32'h0);
        apb_read(12'h08C, d, e);
        chk("evt_pend_kept", d, 32'h1);

        // edge reaching pending in the same cycle as a W1C of that bit
        irq_i = 32'h8;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'h8;
        @(posedge HCLK); #1;
        irq_i = '0; PENABLE = 1'b1;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_read(12'h008, d, e);
        chk("set_beats_clr", d, 32'hC);
        apb_write(12'h008, 32'h8, e);
        apb_read(12'h008, d, e);
        chk("clr_after", d, 32'h4);

        // error responses and EVT_SET
        apb_read(12'h100, d, e);
        chk("badcore_rd_err", 32'(e), 32'h1);
        chk("badcore_rd_data", d, 32'h0);
        apb_write(12'h100, 32'hFFFF_FFFF, e);
        chk("badcore_wr_err", 32'(e), 32'h1);
        apb_write(12'h01C, 32'hFFFF_FFFF, e);
        chk("badreg_wr_err", 32'(e), 32'h1);
        apb_read(12'h01C, d, e);
        chk("badreg_rd_err", 32'(e), 32'h1);
        chk("badreg_rd_data", d, 32'h0);
        apb_read(12'h000, d, e);
        chk("c0_mask_untouched", d, 32'h0);
        chk("good_rd_err", 32'(e), 32'h0);
        apb_write(12'h0CC, 32'hFFFF_FFFF, e);
        apb_write(12'h0D0, 32'h10, e);
        apb_read(12'h0CC, d, e);
        chk("evt_set_c3", d, 32'h10);
        apb_read(12'h08C, d, e);
        chk("evt_set_c2_clean", d, 32'h1);
        apb_read(12'h0D0, d, e);
        chk("evt_set_reads0", d, 32'h0);

        // asynchronous reset while core 0 sleeps
        apb_write(12'h000, 32'h100, e);
        apb_write(12'h004, 32'h100, e);
        apb_read(12'h000, d, e);
        chk("c0_mask_set", d, 32'h100);
        apb_write(12'h014, 32'h1, e);
        @(posedge HCLK); #1;
        chk("c0_sleep_clk", 32'(clk_gate_core_o[0]), 32'h0);
        chk("c0_sleep_fetch", 32'(fetch_enable_o[0]), 32'h0);
        #2 HRESET = 1'b1;
        #1;
        chk("arst_clk", 32'(clk_gate_core_o), 32'hF);
        chk("arst_fetch", 32'(fetch_enable_o), 32'hF);
        chk("arst_irq_o", 32'(|irq_o), 32'h0);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h000;
        #1 chk("arst_irq_mask", PRDATA, 32'h0);
        PADDR = 12'h004;
        #1 chk("arst_evt_mask", PRDATA, 32'h0);
        PADDR = 12'h018;
        #1 chk("arst_status", PRDATA, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        apb_read(12'h000, d, e);
        chk("post_rst_mask", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_event_unit_mc.md
# apb_event_unit_mc

Multi-core, parametrised event/interrupt unit on an APB slave port. For each of NB_CORES cores it holds NB_LINES-wide interrupt and event mask/pending registers fed by edge-detected input lines, drives per-core masked interrupt vectors, and runs an independent sleep/wake FSM. Each FSM gates that core's clock and fetch enable, and wakes the core on any masked pending interrupt or event. It sits in the peripheral subsystem between the APB bus, the interrupt/event sources and the cores' clock gates.

## Interface
- APB_ADDR_WIDTH, 12, APB address width (4 KB slave).
- NB_CORES, 4, number of cores served; 1..8.
- NB_LINES, 32, interrupt/event lines per type; 1..32.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  reset, asynchronous, active-high.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  write data.
- PWRITE, PSEL, PENABLE  in  1 each  APB control.
- PRDATA  out  32  read data.
- PREADY  out  1  always 1.
- PSLVERR  out  1  error response.
- irq_i  in  NB_LINES  interrupt sources, shared by all cores.
- event_i  in  NB_LINES  event sources, shared by all cores.
- irq_o  out  NB_CORES*NB_LINES  masked pending interrupts; core c uses bits [c*NB_LINES +: NB_LINES].
- core_busy_i  in  NB_CORES  core c is busy.
- fetch_enable_o  out  NB_CORES  fetch enable per core.
- clk_gate_core_o  out  NB_CORES  1 means core clock runs.

## Operation
- Decode: core index = PADDR[11:6]; register = PADDR[5:2].
- Core index >= NB_CORES or undefined register: PSLVERR=1 in the access phase; read data 0; write ignored.
- Per-core registers:
  - 0x00 IRQ_MASK: RW.
  - 0x04 EVT_MASK: RW.
  - 0x08 IRQ_PEND: R, write-1-to-clear.
  - 0x0C EVT_PEND: R, write-1-to-clear.
  - 0x10 EVT_SET: W, write-1-to-set EVT_PEND; reads 0.
  - 0x14 SLEEP: write bit0=1 requests sleep.
  - 0x18 STATUS: R, [1:0]=FSM state, [2]=core_busy_i.
- Register bits >= NB_LINES read 0 and ignore writes.
- Edge detection: irq_i and event_i are each registered once. A rising edge on line k sets bit k of IRQ_PEND (resp. EVT_PEND) in every core.
- Set priority: set (edge or EVT_SET) beats a simultaneous W1C of the same bit.
- irq_o slice for core c = IRQ_PEND & IRQ_MASK.
- wake_c = |(IRQ_PEND&IRQ_MASK) | |(EVT_PEND&EVT_MASK).
- Per-core FSM states:
  - RUN: fetch=1, clk=1.
  - WAIT_IDLE: fetch=0, clk=1.
  - SLEEP: fetch=0, clk=0.
  - WAKE: fetch=0, clk=1.
- FSM transitions:
  - RUN -> WAIT_IDLE on SLEEP write with bit0=1.
  - WAIT_IDLE -> RUN if wake_c (sleep aborted).
  - WAIT_IDLE -> SLEEP if core_busy_i[c]=0 and not wake_c.
  - SLEEP -> WAKE on wake_c.
  - WAKE -> RUN after exactly one cycle.
  - A SLEEP write in any state other than RUN is ignored.
- Pending bits are cleared only by software; waking does not clear them.

## Timing
- Reset values: masks 0, pending 0, edge registers 0, every FSM in RUN, fetch_enable_o all 1, clk_gate_core_o all 1, irq_o 0, PRDATA 0, PSLVERR 0, PREADY 1.
- APB: zero wait states. Writes commit on the rising edge ending the access phase (PSEL&PENABLE&PWRITE).
- Reads are combinational from current register state during the access phase. PRDATA is 0 when PSEL=0.
- Input edge to pending bit: 2 cycles (edge register, then pending register).
- Pending to irq_o: combinational, same cycle.
- SLEEP write to fetch_enable_o low: 1 cycle.
- Idle core to clock gated: 1 cycle after core_busy_i=0 is seen in WAIT_IDLE.
- wake_c in SLEEP: clk_gate_core_o high 1 cycle later; fetch_enable_o high 2 cycles later.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). In-flight APB writes are lost.

## Structure
- Package event_unit_mc_pkg holds:
  - register offset localparams;
  - the FSM state enum sleep_state_e (RUN=0, WAIT_IDLE=1, SLEEP=2, WAKE=3);
  - the core-index field bounds.
- Sub-module event_unit_core_ctrl holds one core's masks, pending registers and sleep FSM. It is instantiated NB_CORES times in a generate loop.
- The top level keeps the APB decode, read mux, PSLVERR generation and the shared edge detectors.

## Test plan
- Reset, then read all registers of core 0 -> 0; STATUS=0; fetch_enable_o=all 1; clk_gate_core_o=all 1.
- IRQ_MASK(core1)=0x4; pulse irq_i[2] -> 2 cycles later irq_o[1*NB_LINES+2]=1 and IRQ_PEND=0x4 in all cores; core0 irq_o slice=0. W1C 0x4 -> irq_o cleared.
- EVT_MASK(core2)=0x1; SLEEP write; core_busy_i[2]=1 for 5 cycles then 0 -> STATUS shows 1, then 2 one cycle after busy drops, with clk_gate_core_o[2]=0. Pulse event_i[0] -> WAKE, then RUN, with fetch_enable_o[2] high 2 cycles after the pending bit sets.
- Same cycle as an irq_i[3] edge reaches pending, write W1C 0x8 to IRQ_PEND -> bit 3 stays set.
- Access core index NB_CORES, and register 0x1C -> PSLVERR=1, PRDATA=0, no state change. EVT_SET(core3)=0x10 -> EVT_PEND(core3)=0x10 only.
- HRESET asserted while core 0 is in SLEEP with masks set -> FSM RUN, clock ungated, masks 0, in the same cycle.
